// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue slice.
// Holds the ALU control codes, MIPS opcode/funct values and the FSM state type.
package alu_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RESP
  } state_t;

  typedef enum logic [3:0] {
    ALU_NOP   = 4'h0,
    ALU_ADDU  = 4'h1,
    ALU_SUBU  = 4'h2,
    ALU_SLT   = 4'h3,
    ALU_SLTU  = 4'h4,
    ALU_AND   = 4'h5,
    ALU_NOR   = 4'h6,
    ALU_OR    = 4'h7,
    ALU_XOR   = 4'h8,
    ALU_SLL   = 4'h9,
    ALU_SRL   = 4'hA,
    ALU_SRA   = 4'hB,
    ALU_LUI   = 4'hC,
    ALU_RSV_D = 4'hD,
    ALU_RSV_E = 4'hE,
    ALU_RSV_F = 4'hF
  } alu_op_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

endpackage

// File: rtl/alu_dec.sv
// Combinational decoder: instruction fields to ALU control and operands.
// Anything outside the supported opcode/funct set is flagged illegal.
module alu_dec
  import alu_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [4:0]  shamt,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic [15:0] imm,
  output logic [3:0]  ctrl,
  output logic [31:0] src1,
  output logic [31:0] src2,
  output logic        illegal
);

  logic [31:0] imm_sx;
  logic [31:0] imm_zx;

  assign imm_sx = {{16{imm[15]}}, imm};
  assign imm_zx = {16'h0000, imm};

  always_comb begin
    ctrl    = ALU_NOP;
    src1    = rs;
    src2    = rt;
    illegal = 1'b0;
    if (opcode == OP_RTYPE) begin
      unique case (funct)
        F_ADDU: ctrl = ALU_ADDU;
        F_SUBU: ctrl = ALU_SUBU;
        F_SLT:  ctrl = ALU_SLT;
        F_SLTU: ctrl = ALU_SLTU;
        F_AND:  ctrl = ALU_AND;
        F_NOR:  ctrl = ALU_NOR;
        F_OR:   ctrl = ALU_OR;
        F_XOR:  ctrl = ALU_XOR;
        F_SLL: begin
          ctrl = ALU_SLL;
          src1 = {27'b0, shamt};
        end
        F_SRL: begin
          ctrl = ALU_SRL;
          src1 = {27'b0, shamt};
        end
        F_SRA: begin
          ctrl = ALU_SRA;
          src1 = {27'b0, shamt};
        end
        F_SLLV: ctrl = ALU_SLL;
        F_SRLV: ctrl = ALU_SRL;
        F_SRAV: ctrl = ALU_SRA;
        default: illegal = 1'b1;
      endcase
    end else begin
      // lui shifts the zero-extended immediate inside the ALU
      src2 = imm_zx;
      unique case (opcode)
        OP_ADDIU: begin
          ctrl = ALU_ADDU;
          src2 = imm_sx;
        end
        OP_SLTI: begin
          ctrl = ALU_SLT;
          src2 = imm_sx;
        end
        OP_SLTIU: begin
          ctrl = ALU_SLTU;
          src2 = imm_sx;
        end
        OP_ANDI: ctrl = ALU_AND;
        OP_ORI:  ctrl = ALU_OR;
        OP_XORI: ctrl = ALU_XOR;
        OP_LUI:  ctrl = ALU_LUI;
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue.sv
// Issues one decoded command to an external combinational ALU and
// returns its result through a valid/ready response port.
module alu_issue
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_opcode,
  input  logic [5:0]  cmd_funct,
  input  logic [4:0]  cmd_shamt,
  input  logic [31:0] cmd_rs,
  input  logic [31:0] cmd_rt,
  input  logic [15:0] cmd_imm,
  output logic [3:0]  alu_control,
  output logic [31:0] alu_src1,
  output logic [31:0] alu_src2,
  input  logic [31:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_illegal,
  output logic [15:0] op_count
);

  state_t      state;
  state_t      state_n;
  logic [3:0]  dec_ctrl;
  logic [31:0] dec_src1;
  logic [31:0] dec_src2;
  logic        dec_illegal;
  logic        accept;
  logic        done;

  alu_dec u_dec (
    .opcode  (cmd_opcode),
    .funct   (cmd_funct),
    .shamt   (cmd_shamt),
    .rs      (cmd_rs),
    .rt      (cmd_rt),
    .imm     (cmd_imm),
    .ctrl    (dec_ctrl),
    .src1    (dec_src1),
    .src2    (dec_src2),
    .illegal (dec_illegal)
  );

  assign accept = cmd_valid & cmd_ready;
  assign done   = rsp_valid & rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: begin
        if (accept) state_n = dec_illegal ? S_RESP : S_ISSUE;
      end
      S_ISSUE: state_n = S_RESP;
      S_RESP: begin
        if (rsp_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == S_IDLE);
    rsp_valid = (state == S_RESP);
  end

  // alu_control is a one-shot pulse; operands keep their last issued value
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_control <= ALU_NOP;
      alu_src1    <= '0;
      alu_src2    <= '0;
      rsp_result  <= '0;
      rsp_illegal <= 1'b0;
      op_count    <= '0;
    end else begin
      alu_control <= ALU_NOP;
      if (accept && !dec_illegal) begin
        alu_control <= dec_ctrl;
        alu_src1    <= dec_src1;
        alu_src2    <= dec_src2;
      end
      if (accept && dec_illegal) begin
        rsp_result  <= '0;
        rsp_illegal <= 1'b1;
      end
      if (state == S_ISSUE) begin
        rsp_result  <= alu_result;
        rsp_illegal <= 1'b0;
      end
      if (done && !rsp_illegal && op_count != 16'hFFFF)
        op_count <= op_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue with a behavioural ALU stub.
// Expected results come from an instruction-level reference model.
module tb_alu_issue;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [5:0]  cmd_opcode;
  logic [5:0]  cmd_funct;
  logic [4:0]  cmd_shamt;
  logic [31:0] cmd_rs;
  logic [31:0] cmd_rt;
  logic [15:0] cmd_imm;
  logic [3:0]  alu_control;
  logic [31:0] alu_src1;
  logic [31:0] alu_src2;
  logic [31:0] alu_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_illegal;
  logic [15:0] op_count;

  int total = 0;
  int bad = 0;
  logic [15:0] exp_cnt = 16'h0;

  typedef struct packed {
    logic        ill;
    logic [3:0]  ctrl;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] res;
  } exp_t;

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] res;
    logic        ill;
    int          lat;
    int          wait_n;
    logic        stable;
    logic        rdy_seen;
    logic        rdy_after;
    logic        timeout;
  } obs_t;

  typedef struct packed {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  sh;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [15:0] imm;
    logic [3:0]  ctrl;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] res;
  } vec_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  alu_issue dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_opcode  (cmd_opcode),
    .cmd_funct   (cmd_funct),
    .cmd_shamt   (cmd_shamt),
    .cmd_rs      (cmd_rs),
    .cmd_rt      (cmd_rt),
    .cmd_imm     (cmd_imm),
    .alu_control (alu_control),
    .alu_src1    (alu_src1),
    .alu_src2    (alu_src2),
    .alu_result  (alu_result),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_illegal (rsp_illegal),
    .op_count    (op_count)
  );

  // external combinational ALU
  always_comb begin
    alu_result = 32'h0;
    case (alu_control)
      4'h1: alu_result = alu_src1 + alu_src2;
      4'h2: alu_result = alu_src1 - alu_src2;
      4'h3: alu_result = {31'b0, $signed(alu_src1) < $signed(alu_src2)};
      4'h4: alu_result = {31'b0, alu_src1 < alu_src2};
      4'h5: alu_result = alu_src1 & alu_src2;
      4'h6: alu_result = ~(alu_src1 | alu_src2);
      4'h7: alu_result = alu_src1 | alu_src2;
      4'h8: alu_result = alu_src1 ^ alu_src2;
      4'h9: alu_result = alu_src2 << alu_src1[4:0];
      4'hA: alu_result = alu_src2 >> alu_src1[4:0];
      4'hB: alu_result = $unsigned($signed(alu_src2) >>> alu_src1[4:0]);
      4'hC: alu_result = alu_src2 << 16;
      default: alu_result = 32'h0;
    endcase
  end

  function automatic exp_t ref_op(input logic [5:0] op, input logic [5:0] fn,
                                  input logic [4:0] sh, input logic [31:0] rs,
                                  input logic [31:0] rt, input logic [15:0] imm);
    exp_t e;
    logic [31:0] sx;
    logic [31:0] zx;
    sx = {{16{imm[15]}}, imm};
    zx = {16'h0, imm};
    e = '0;
    e.s1 = rs;
    e.s2 = rt;
    if (op == 6'h00) begin
      case (fn)
        6'h21: begin e.ctrl = 4'h1; e.res = rs + rt; end
        6'h23: begin e.ctrl = 4'h2; e.res = rs - rt; end
        6'h2A: begin e.ctrl = 4'h3; e.res = {31'b0, $signed(rs) < $signed(rt)}; end
        6'h2B: begin e.ctrl = 4'h4; e.res = {31'b0, rs < rt}; end
        6'h24: begin e.ctrl = 4'h5; e.res = rs & rt; end
        6'h27: begin e.ctrl = 4'h6; e.res = ~(rs | rt); end
        6'h25: begin e.ctrl = 4'h7; e.res = rs | rt; end
        6'h26: begin e.ctrl = 4'h8; e.res = rs ^ rt; end
        6'h00: begin e.ctrl = 4'h9; e.s1 = {27'b0, sh}; e.res = rt << sh; end
        6'h02: begin e.ctrl = 4'hA; e.s1 = {27'b0, sh}; e.res = rt >> sh; end
        6'h03: begin
          e.ctrl = 4'hB; e.s1 = {27'b0, sh};
          e.res = $unsigned($signed(rt) >>> sh);
        end
        6'h04: begin e.ctrl = 4'h9; e.res = rt << rs[4:0]; end
        6'h06: begin e.ctrl = 4'hA; e.res = rt >> rs[4:0]; end
        6'h07: begin e.ctrl = 4'hB; e.res = $unsigned($signed(rt) >>> rs[4:0]); end
        default: e.ill = 1'b1;
      endcase
    end else begin
      case (op)
        6'h09: begin e.ctrl = 4'h1; e.s2 = sx; e.res = rs + sx; end
        6'h0A: begin e.ctrl = 4'h3; e.s2 = sx; e.res = {31'b0, $signed(rs) < $signed(sx)}; end
        6'h0B: begin e.ctrl = 4'h4; e.s2 = sx; e.res = {31'b0, rs < sx}; end
        6'h0C: begin e.ctrl = 4'h5; e.s2 = zx; e.res = rs & zx; end
        6'h0D: begin e.ctrl = 4'h7; e.s2 = zx; e.res = rs | zx; end
        6'h0E: begin e.ctrl = 4'h8; e.s2 = zx; e.res = rs ^ zx; end
        6'h0F: begin e.ctrl = 4'hC; e.s2 = zx; e.res = {imm, 16'h0}; end
        default: e.ill = 1'b1;
      endcase
    end
    if (e.ill) begin
      e.ctrl = 4'h0;
      e.res = 32'h0;
    end
    return e;
  endfunction

  // drives one command from a negedge, observes issue/response, handshakes
  task automatic do_op(input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] sh, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [15:0] imm,
                       input int hold, input bit keep, output obs_t o);
    o = '{default: 0};
    cmd_valid = 1'b1;
    cmd_opcode = op;
    cmd_funct = fn;
    cmd_shamt = sh;
    cmd_rs = rs;
    cmd_rt = rt;
    cmd_imm = imm;
    while (!cmd_ready && o.wait_n < 20) begin
      @(negedge clk);
      o.wait_n++;
    end
    if (!cmd_ready) begin
      o.timeout = 1'b1;
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    sb.push_back(ref_op(op, fn, sh, rs, rt, imm));
    @(negedge clk);
    if (!keep) cmd_valid = 1'b0;
    o.ctrl = alu_control;
    o.s1 = alu_src1;
    o.s2 = alu_src2;
    o.lat = 1;
    o.rdy_seen = cmd_ready;
    while (!rsp_valid && o.lat < 10) begin
      @(negedge clk);
      o.lat++;
      o.rdy_seen |= cmd_ready;
    end
    if (!rsp_valid) begin
      o.timeout = 1'b1;
      return;
    end
    o.res = rsp_result;
    o.ill = rsp_illegal;
    o.stable = 1'b1;
    repeat (hold) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_result !== o.res || rsp_illegal !== o.ill)
        o.stable = 1'b0;
      o.rdy_seen |= cmd_ready;
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    o.rdy_after = cmd_ready;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    cmd_opcode = '0;
    cmd_funct = '0;
    cmd_shamt = '0;
    cmd_rs = '0;
    cmd_rt = '0;
    cmd_imm = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 16'h0;
    total++;
    if ({cmd_ready, rsp_valid, rsp_illegal} !== 3'b100) begin
      bad++;
      $display("FAIL reset_hs got=%b exp=100", {cmd_ready, rsp_valid, rsp_illegal});
    end
    total++;
    if ({alu_control, op_count} !== 20'h0) begin
      bad++;
      $display("FAIL reset_ctl_cnt got=%h/%h exp=0/0", alu_control, op_count);
    end
    total++;
    if ({alu_src1, alu_src2, rsp_result} !== 96'h0) begin
      bad++;
      $display("FAIL reset_data got=%h/%h/%h exp=0", alu_src1, alu_src2, rsp_result);
    end
  endtask

  task automatic test_vectors();
    vec_t v[8];
    obs_t o;
    exp_t e;
    v[0] = '{6'h00, 6'h21, 5'd0, 32'd5, 32'd7, 16'h0,
             4'h1, 32'd5, 32'd7, 32'd12};
    v[1] = '{6'h00, 6'h03, 5'd4, 32'd0, 32'h80000000, 16'h0,
             4'hB, 32'd4, 32'h80000000, 32'hF8000000};
    v[2] = '{6'h09, 6'h00, 5'd0, 32'd1, 32'd0, 16'hFFFF,
             4'h1, 32'd1, 32'hFFFFFFFF, 32'h0};
    v[3] = '{6'h0C, 6'h00, 5'd0, 32'h12345678, 32'd0, 16'hFFFF,
             4'h5, 32'h12345678, 32'h0000FFFF, 32'h00005678};
    v[4] = '{6'h0F, 6'h00, 5'd0, 32'd0, 32'd0, 16'h1234,
             4'hC, 32'd0, 32'h00001234, 32'h12340000};
    v[5] = '{6'h00, 6'h04, 5'd0, 32'd3, 32'd1, 16'h0,
             4'h9, 32'd3, 32'd1, 32'd8};
    v[6] = '{6'h00, 6'h2A, 5'd0, 32'hFFFFFFFF, 32'd1, 16'h0,
             4'h3, 32'hFFFFFFFF, 32'd1, 32'd1};
    v[7] = '{6'h0B, 6'h00, 5'd0, 32'd1, 32'd0, 16'hFFFF,
             4'h4, 32'd1, 32'hFFFFFFFF, 32'd1};
    for (int i = 0; i < 8; i++) begin
      do_op(v[i].op, v[i].fn, v[i].sh, v[i].rs, v[i].rt, v[i].imm, 0, 1'b0, o);
      total++;
      if (o.timeout || sb.size() == 0) begin
        bad++;
        $display("FAIL vec%0d_timeout", i);
        continue;
      end
      e = sb.pop_front();
      if (!e.ill) exp_cnt = (exp_cnt == 16'hFFFF) ? exp_cnt : exp_cnt + 16'd1;
      if ({o.ctrl, o.s1, o.s2} !== {v[i].ctrl, v[i].s1, v[i].s2}) begin
        bad++;
        $display("FAIL vec%0d_issue got=%h/%h/%h exp=%h/%h/%h", i,
                 o.ctrl, o.s1, o.s2, v[i].ctrl, v[i].s1, v[i].s2);
      end
      total++;
      if (o.res !== v[i].res || o.res !== e.res || o.ill !== 1'b0) begin
        bad++;
        $display("FAIL vec%0d_result got=%h ill=%b exp=%h", i, o.res, o.ill, v[i].res);
      end
      total++;
      if (o.lat !== 2) begin
        bad++;
        $display("FAIL vec%0d_latency got=%0d exp=2", i, o.lat);
      end
      total++;
      if (op_count !== exp_cnt) begin
        bad++;
        $display("FAIL vec%0d_count got=%h exp=%h", i, op_count, exp_cnt);
      end
    end
  endtask

  task automatic test_random();
    logic [11:0] legal[21];
    logic [11:0] pick;
    logic [5:0] fn;
    obs_t o;
    exp_t e;
    legal = '{12'h021, 12'h023, 12'h02A, 12'h02B, 12'h024, 12'h027, 12'h025,
              12'h026, 12'h000, 12'h002, 12'h003, 12'h004, 12'h006, 12'h007,
              12'h240, 12'h280, 12'h2C0, 12'h300, 12'h340, 12'h380, 12'h3C0};
    for (int i = 0; i < 30; i++) begin
      pick = legal[$urandom_range(0, 20)];
      fn = (pick[11:6] == 6'h00) ? pick[5:0] : 6'($urandom);
      do_op(pick[11:6], fn, 5'($urandom), $urandom, $urandom, 16'($urandom),
            $urandom_range(0, 2), 1'b0, o);
      total++;
      if (o.timeout || sb.size() == 0) begin
        bad++;
        $display("FAIL rand%0d_timeout", i);
        continue;
      end
      e = sb.pop_front();
      if (!e.ill) exp_cnt = (exp_cnt == 16'hFFFF) ? exp_cnt : exp_cnt + 16'd1;
      if ({o.ctrl, o.s1, o.s2} !== {e.ctrl, e.s1, e.s2}) begin
        bad++;
        $display("FAIL rand%0d_issue op=%h fn=%h got=%h/%h/%h exp=%h/%h/%h", i,
                 pick[11:6], fn, o.ctrl, o.s1, o.s2, e.ctrl, e.s1, e.s2);
      end
      total++;
      if (o.res !== e.res || o.ill !== 1'b0 || o.lat !== 2 || o.stable !== 1'b1) begin
        bad++;
        $display("FAIL rand%0d_rsp got=%h ill=%b lat=%0d st=%b exp=%h", i,
                 o.res, o.ill, o.lat, o.stable, e.res);
      end
      total++;
      if (op_count !== exp_cnt) begin
        bad++;
        $display("FAIL rand%0d_count got=%h exp=%h", i, op_count, exp_cnt);
      end
    end
  endtask

  task automatic test_illegal();
    logic [11:0] ill[3];
    obs_t o;
    exp_t e;
    ill = '{12'hFFF, 12'h001, 12'h080};
    for (int i = 0; i < 3; i++) begin
      do_op(ill[i][11:6], ill[i][5:0], 5'd3, 32'hDEAD, 32'hBEEF, 16'h1111,
            1, 1'b0, o);
      total++;
      if (o.timeout || sb.size() == 0) begin
        bad++;
        $display("FAIL ill%0d_timeout", i);
        continue;
      end
      e = sb.pop_front();
      if (o.lat !== 1 || o.ctrl !== 4'h0) begin
        bad++;
        $display("FAIL ill%0d_noissue lat=%0d ctrl=%h exp lat=1 ctrl=0", i, o.lat, o.ctrl);
      end
      total++;
      if (o.ill !== e.ill || o.res !== e.res || o.ill !== 1'b1) begin
        bad++;
        $display("FAIL ill%0d_rsp got=%b/%h exp=1/0", i, o.ill, o.res);
      end
      total++;
      if (op_count !== exp_cnt) begin
        bad++;
        $display("FAIL ill%0d_count got=%h exp=%h", i, op_count, exp_cnt);
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    exp_t e;
    do_op(6'h00, 6'h21, 5'd0, 32'd100, 32'd23, 16'h0, 3, 1'b1, o);
    total++;
    if (o.timeout || sb.size() == 0) begin
      bad++;
      $display("FAIL b2b_first_timeout");
    end else begin
      e = sb.pop_front();
      exp_cnt = (exp_cnt == 16'hFFFF) ? exp_cnt : exp_cnt + 16'd1;
      if (o.stable !== 1'b1 || o.res !== e.res) begin
        bad++;
        $display("FAIL b2b_stable got=%b/%h exp=1/%h", o.stable, o.res, e.res);
      end
      total++;
      if (o.rdy_seen !== 1'b0 || o.rdy_after !== 1'b1) begin
        bad++;
        $display("FAIL b2b_ready busy=%b after=%b exp=0/1", o.rdy_seen, o.rdy_after);
      end
    end
    do_op(6'h00, 6'h23, 5'd0, 32'd10, 32'd11, 16'h0, 0, 1'b0, o);
    total++;
    if (o.timeout || sb.size() == 0) begin
      bad++;
      $display("FAIL b2b_second_timeout");
    end else begin
      e = sb.pop_front();
      exp_cnt = (exp_cnt == 16'hFFFF) ? exp_cnt : exp_cnt + 16'd1;
      if (o.wait_n !== 0 || o.res !== e.res || op_count !== exp_cnt) begin
        bad++;
        $display("FAIL b2b_second wait=%0d res=%h cnt=%h exp=0/%h/%h",
                 o.wait_n, o.res, op_count, e.res, exp_cnt);
      end
    end
  endtask

  task automatic test_rst_mid();
    int n;
    logic seen;
    cmd_opcode = 6'h00;
    cmd_funct = 6'h21;
    cmd_rs = 32'd9;
    cmd_rt = 32'd9;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    total++;
    if (alu_control !== 4'h1) begin
      bad++;
      $display("FAIL rstmid_in_issue got=%h exp=1", alu_control);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 16'h0;
    total++;
    if ({cmd_ready, rsp_valid, rsp_illegal, alu_control, op_count} !== {3'b100, 20'h0} ||
        {alu_src1, alu_src2, rsp_result} !== 96'h0) begin
      bad++;
      $display("FAIL rstmid_values rdy=%b v=%b ctl=%h cnt=%h s1=%h s2=%h r=%h",
               cmd_ready, rsp_valid, alu_control, op_count, alu_src1, alu_src2, rsp_result);
    end
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen |= rsp_valid;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_no_rsp got=%b exp=0", seen);
    end
  endtask

  task automatic test_saturate();
    obs_t o;
    exp_t e;
    @(negedge clk);
    force dut.op_count = 16'hFFFE;
    #1;
    release dut.op_count;
    exp_cnt = 16'hFFFE;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      do_op(6'h09, 6'h00, 5'd0, 32'd1, 32'd0, 16'd1, 0, 1'b0, o);
      total++;
      if (o.timeout || sb.size() == 0) begin
        bad++;
        $display("FAIL sat%0d_timeout", i);
        continue;
      end
      e = sb.pop_front();
      exp_cnt = (exp_cnt == 16'hFFFF) ? exp_cnt : exp_cnt + 16'd1;
      if (op_count !== exp_cnt || o.res !== e.res) begin
        bad++;
        $display("FAIL sat%0d_count got=%h res=%h exp=%h/%h", i, op_count, o.res, exp_cnt, e.res);
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_vectors();
    test_random();
    test_illegal();
    test_back_to_back();
    test_rst_mid();
    test_saturate();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_left got=%0d exp=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
